// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its companion detector.
// Holds the FSM state encoding, field widths and the length-legality helper.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } seq_state_t;

  localparam int LEN_W = 5;
  localparam int REP_W = 4;
  localparam int GAP_W = 4;

  function automatic logic len_legal(input logic [LEN_W-1:0] len, input logic [LEN_W:0] max_len);
    return (len != 5'd0) && ({1'b0, len} <= max_len);
  endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// Down-counter that times the idle gap between pattern repetitions.
// A load presets the count; expired is high while the count sits at zero.
module seq_gap_timer
  import seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [GAP_W-1:0] cnt;

  // Count register: load wins over decrement, saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end else begin
      cnt <= cnt;
    end
  end

  assign expired = (cnt == 4'd0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends a captured bit pattern MSB-first, optionally
// repeated with idle gaps. All outputs are registered one cycle behind the FSM state.
module seq_gen
  import seq_pkg::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [REP_W-1:0]   repeat_cnt,
  input  logic               abort,
  output logic               data,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         state_out
);

  localparam int               IW        = $clog2(MAX_LEN) + 1;
  localparam logic [LEN_W:0]   MAX_LEN_V = (LEN_W + 1)'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? 4'd0 : GAP_W'(GAP_CYCLES - 1);
  localparam bit               NO_GAP    = (GAP_CYCLES == 0);

  seq_state_t         state, state_next;
  logic [MAX_LEN-1:0] pattern_r, pattern_next, shifted;
  logic [IW-1:0]      idx_r, idx_next, last_r, last_next;
  logic [REP_W-1:0]   rep_r, rep_next;
  logic               data_next, valid_next, err_next;
  logic               gap_load, gap_en, gap_expired;

  seq_gap_timer u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (gap_en),
    .expired  (gap_expired)
  );

  // Next-state, capture and output-next logic
  always_comb begin
    state_next   = state;
    pattern_next = pattern_r;
    last_next    = last_r;
    idx_next     = idx_r;
    rep_next     = rep_r;
    data_next    = 1'b0;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    gap_load     = 1'b0;
    gap_en       = 1'b0;
    shifted      = pattern_r >> idx_r;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_legal(length, MAX_LEN_V)) begin
            pattern_next = pattern;
            last_next    = IW'(length - 5'd1);
            idx_next     = IW'(length - 5'd1);
            rep_next     = repeat_cnt;
            state_next   = SEND;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SEND: begin
        // An abort truncates: the bit of this cycle is dropped
        if (abort) begin
          state_next = DONE;
        end else begin
          data_next  = shifted[0];
          valid_next = 1'b1;
          if (idx_r != '0) begin
            idx_next = idx_r - IW'(1);
          end else if (rep_r == 4'd1) begin
            state_next = DONE;
          end else begin
            if (rep_r != 4'd0) begin
              rep_next = rep_r - 4'd1;
            end else begin
              rep_next = rep_r;
            end
            idx_next = last_r;
            if (NO_GAP) begin
              state_next = SEND;
            end else begin
              state_next = GAP;
              gap_load   = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_next = DONE;
        end else if (gap_expired) begin
          state_next = SEND;
        end else begin
          gap_en = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, captured transmission context and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pattern_r <= '0;
      last_r    <= '0;
      idx_r     <= '0;
      rep_r     <= 4'd0;
      data      <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      state_out <= 2'b00;
    end else begin
      state     <= state_next;
      pattern_r <= pattern_next;
      last_r    <= last_next;
      idx_r     <= idx_next;
      rep_r     <= rep_next;
      data      <= data_next;
      valid     <= valid_next;
      busy      <= (state != IDLE);
      done      <= (state == DONE);
      err       <= err_next;
      state_out <= state;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen (MAX_LEN=16, GAP_CYCLES=1).
module tb_seq_gen;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic [3:0]  repeat_cnt;
  logic        data, valid, busy, done, err;
  logic [1:0]  state_out;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  seq_gen #(.MAX_LEN(16), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .length(length),
    .repeat_cnt(repeat_cnt), .abort(abort), .data(data), .valid(valid),
    .busy(busy), .done(done), .err(err), .state_out(state_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r);
    pattern = p; length = l; repeat_cnt = r; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = 16'h0; length = 5'd0; repeat_cnt = 4'd0;
    tick(); tick();
    checks++; if ({data, valid, busy, done, err} !== 5'b00000) begin errors++; $display("FAIL reset_outs got=%b exp=00000", {data, valid, busy, done, err}); end
    checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", state_out); end
    rst = 1'b0;
    tick();
    checks++; if ({busy, state_out} !== 3'b000) begin errors++; $display("FAIL reset_idle got=%b exp=000", {busy, state_out}); end
  endtask

  task automatic test_single();
    logic [3:0] exp_bits;
    exp_bits = 4'b1010;
    do_start(16'h000A, 5'd4, 4'd1);
    pattern = 16'h0000;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_latency valid got=%b exp=0", valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({data, valid} !== {exp_bits[3-i], 1'b1}) begin errors++; $display("FAIL single_bit%0d got=%b exp=%b", i, {data, valid}, {exp_bits[3-i], 1'b1}); end
      checks++; if ({busy, state_out} !== 3'b101) begin errors++; $display("FAIL single_state%0d got=%b exp=101", i, {busy, state_out}); end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({done, data, valid, state_out} !== 5'b10011) begin errors++; $display("FAIL single_done got=%b exp=10011", {done, data, valid, state_out}); end
    tick();
    checks++; if ({done, state_out} !== 3'b000) begin errors++; $display("FAIL single_idle got=%b exp=000", {done, state_out}); end
    tick();
    checks++; if ({busy, valid, state_out} !== 4'b0000) begin errors++; $display("FAIL single_start_in_done got=%b exp=0000", {busy, valid, state_out}); end
  endtask

  task automatic test_repeat();
    logic exp_d [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_v [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_start(16'h0005, 5'd3, 4'd3);
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++; if ({data, valid, done} !== {exp_d[i], exp_v[i], 1'b0}) begin errors++; $display("FAIL repeat_cyc%0d got=%b exp=%b", i, {data, valid, done}, {exp_d[i], exp_v[i], 1'b0}); end
    end
    tick();
    checks++; if ({done, valid} !== 2'b10) begin errors++; $display("FAIL repeat_done got=%b exp=10", {done, valid}); end
    tick();
    checks++; if ({done, state_out} !== 3'b000) begin errors++; $display("FAIL repeat_single_done got=%b exp=000", {done, state_out}); end
  endtask

  task automatic test_err();
    logic [4:0] bad [2] = '{5'd0, 5'd17};
    for (int j = 0; j < 2; j++) begin
      do_start(16'hFFFF, bad[j], 4'd1);
      checks++; if ({err, busy, valid} !== 3'b100) begin errors++; $display("FAIL err_pulse len=%0d got=%b exp=100", bad[j], {err, busy, valid}); end
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++; if ({err, busy, data, valid, state_out} !== 6'b000000) begin errors++; $display("FAIL err_quiet len=%0d got=%b exp=000000", bad[j], {err, busy, data, valid, state_out}); end
      end
    end
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    do_start(16'h0002, 5'd2, 4'd0);
    for (int c = 0; c < 40 && seen < 7; c++) begin
      tick();
      if (valid) seen++;
    end
    checks++; if (seen !== 7) begin errors++; $display("FAIL abort_bits got=%0d exp=7", seen); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({data, valid, done} !== 3'b000) begin errors++; $display("FAIL abort_cut got=%b exp=000", {data, valid, done}); end
    tick();
    checks++; if ({done, data, valid, state_out} !== 5'b10011) begin errors++; $display("FAIL abort_done got=%b exp=10011", {done, data, valid, state_out}); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ({done, data, valid, busy} !== 4'b0000) begin errors++; $display("FAIL abort_after%0d got=%b exp=0000", c, {done, data, valid, busy}); end
    end
  endtask

  task automatic test_back_to_back_abort();
    int dones;
    dones = 0;
    do_start(16'h0002, 5'd2, 4'd1);
    tick();
    checks++; if ({data, valid} !== 2'b11) begin errors++; $display("FAIL coinc_first got=%b exp=11", {data, valid}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done) dones++;
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL coinc_done_count got=%0d exp=1", dones); end
    abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ({done, busy, state_out} !== 4'b0000) begin errors++; $display("FAIL abort_idle%0d got=%b exp=0000", c, {done, busy, state_out}); end
    end
    abort = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [15:0] p;
    p = 16'hC3A5;
    do_start(16'h000A, 5'd4, 4'd0);
    tick(); tick();
    #3;
    rst = 1'b1;
    #1;
    checks++; if ({data, valid, busy, done, err, state_out} !== 7'b0000000) begin errors++; $display("FAIL rst_async got=%b exp=0000000", {data, valid, busy, done, err, state_out}); end
    @(posedge clk);
    #2;
    checks++; if ({done, busy, state_out} !== 4'b0000) begin errors++; $display("FAIL rst_hold got=%b exp=0000", {done, busy, state_out}); end
    rst = 1'b0;
    tick();
    do_start(p, 5'd16, 4'd1);
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if ({data, valid} !== {p[15-i], 1'b1}) begin errors++; $display("FAIL rst_restart_bit%0d got=%b exp=%b", i, {data, valid}, {p[15-i], 1'b1}); end
    end
    tick();
    checks++; if ({done, valid} !== 2'b10) begin errors++; $display("FAIL rst_restart_done got=%b exp=10", {done, valid}); end
    tick();
    checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL rst_restart_idle got=%b exp=00", state_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_err();
    test_abort();
    test_back_to_back_abort();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
